// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encodings,
// FSM states and divider constants.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  localparam int unsigned DIV_ITER         = 32;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic op_is_signed_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift remainder:quotient left, trial
// subtract the divisor and keep the difference when it is non-negative.
module muldiv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // Trial subtraction; the top bit of the difference flags a negative result
  always_comb begin
    shifted_s = {rem, quo[XLEN-1]};
    diff_s    = shifted_s - {1'b0, dvsr};
    if (diff_s[XLEN]) begin
      rem_next = shifted_s[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_next = diff_s[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the RV32M resource: fixed-latency multiplier plus a
// 32-iteration restoring divider, stalling the pipe until the result is ready.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            ex_muldiv_req,
  input  logic [2:0]      ex_muldiv_op,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_flush,
  input  logic            ex_stall,
  output logic            muldiv_stall_req,
  output logic            muldiv_done,
  output logic [XLEN-1:0] muldiv_result
);

  muldiv_state_e   state_r;
  muldiv_op_e      op_r;
  logic [4:0]      cnt_r;
  logic [XLEN-1:0] a_r, b_r;
  logic [XLEN-1:0] rem_r, quo_r, dvsr_r;
  logic            neg_q_r, neg_r_r;
  logic [XLEN-1:0] result_r;

  muldiv_op_e      acc_op_s;
  logic            acc_signed_s, acc_rem_s, div_zero_s, div_ovf_s;
  logic            neg_a_s, neg_b_s;
  logic [XLEN-1:0] abs_a_s, abs_b_s, special_res_s;
  logic            mul_a_sign_s, mul_b_sign_s;
  logic [2*XLEN-1:0] mul_prod_s;
  logic [XLEN-1:0] mul_res_s, div_res_s;
  logic [XLEN-1:0] rem_nx_s, quo_nx_s;

  // Decode of the incoming instruction: special divide cases and magnitudes
  always_comb begin
    acc_op_s     = muldiv_op_e'(ex_muldiv_op);
    acc_signed_s = op_is_signed_div(acc_op_s);
    acc_rem_s    = ex_muldiv_op[1];
    div_zero_s   = (ex_rs2 == {XLEN{1'b0}});
    div_ovf_s    = acc_signed_s && (ex_rs1 == DIV_OVF_DIVIDEND) && (ex_rs2 == {XLEN{1'b1}});
    neg_a_s      = acc_signed_s & ex_rs1[XLEN-1];
    neg_b_s      = acc_signed_s & ex_rs2[XLEN-1];
    abs_a_s      = neg_a_s ? -ex_rs1 : ex_rs1;
    abs_b_s      = neg_b_s ? -ex_rs2 : ex_rs2;
    if (div_zero_s) begin
      special_res_s = acc_rem_s ? ex_rs1 : {XLEN{1'b1}};
    end else if (div_ovf_s) begin
      special_res_s = acc_rem_s ? {XLEN{1'b0}} : DIV_OVF_DIVIDEND;
    end else begin
      special_res_s = {XLEN{1'b0}};
    end
  end

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvsr     (dvsr_r),
    .rem_next (rem_nx_s),
    .quo_next (quo_nx_s)
  );

  // Final-cycle results: extended-operand product and sign-corrected quotient/remainder
  always_comb begin
    mul_a_sign_s = (op_r != OP_MULHU) & a_r[XLEN-1];
    mul_b_sign_s = (op_r == OP_MULH) & b_r[XLEN-1];
    mul_prod_s   = {{XLEN{mul_a_sign_s}}, a_r} * {{XLEN{mul_b_sign_s}}, b_r};
    mul_res_s    = (op_r == OP_MUL) ? mul_prod_s[XLEN-1:0] : mul_prod_s[2*XLEN-1:XLEN];
    if ((op_r == OP_REM) || (op_r == OP_REMU)) begin
      div_res_s = neg_r_r ? -rem_nx_s : rem_nx_s;
    end else begin
      div_res_s = neg_q_r ? -quo_nx_s : quo_nx_s;
    end
  end

  // Sequencer FSM with registered result; flush discards any in-flight work
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_MUL;
      cnt_r    <= 5'd0;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      rem_r    <= {XLEN{1'b0}};
      quo_r    <= {XLEN{1'b0}};
      dvsr_r   <= {XLEN{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else if (ex_flush) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ex_muldiv_req) begin
            op_r <= acc_op_s;
            a_r  <= ex_rs1;
            b_r  <= ex_rs2;
            if (!ex_muldiv_op[2]) begin
              state_r <= ST_MUL;
              cnt_r   <= 5'(MUL_LATENCY - 1);
            end else if (div_zero_s || div_ovf_s) begin
              state_r  <= ST_DONE;
              result_r <= special_res_s;
            end else begin
              state_r <= ST_DIV;
              cnt_r   <= 5'(DIV_ITER - 1);
              rem_r   <= {XLEN{1'b0}};
              quo_r   <= abs_a_s;
              dvsr_r  <= abs_b_s;
              neg_q_r <= neg_a_s ^ neg_b_s;
              neg_r_r <= neg_a_s;
            end
          end
        end
        ST_MUL: begin
          if (cnt_r == 5'd0) begin
            state_r  <= ST_DONE;
            result_r <= mul_res_s;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        ST_DIV: begin
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          if (cnt_r == 5'd0) begin
            state_r  <= ST_DONE;
            result_r <= div_res_s;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        ST_DONE: begin
          if (!ex_stall) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign muldiv_stall_req = ex_muldiv_req & (state_r != ST_DONE) & ~ex_flush;
  assign muldiv_done      = (state_r == ST_DONE);
  assign muldiv_result    = result_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed RV32M cases plus randomized
// back-to-back traffic against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int XLEN        = 32;
  localparam int MUL_LATENCY = 2;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            ex_muldiv_req;
  logic [2:0]      ex_muldiv_op;
  logic [XLEN-1:0] ex_rs1, ex_rs2;
  logic            ex_flush, ex_stall;
  logic            muldiv_stall_req, muldiv_done;
  logic [XLEN-1:0] muldiv_result;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY)) dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .ex_muldiv_req    (ex_muldiv_req),
    .ex_muldiv_op     (ex_muldiv_op),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_flush         (ex_flush),
    .ex_stall         (ex_stall),
    .muldiv_stall_req (muldiv_stall_req),
    .muldiv_done      (muldiv_done),
    .muldiv_result    (muldiv_result)
  );

  always #5 clk = ~clk;

  // Reference model: RV32M semantics from plain 64-bit and signed 32-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, prod;
    longint unsigned ua, ub, uprod;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin prod = sa * sb; return prod[31:0]; end
      3'd1: begin prod = sa * sb; return prod[63:32]; end
      3'd2: begin prod = sa * longint'(ub); return prod[63:32]; end
      3'd3: begin uprod = ua * ub; return uprod[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1 + MUL_LATENCY;
    if (b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one instruction (called just after a falling edge), holds ex_stall for
  // 'hold' DONE cycles, then lets EX advance and checks done drops.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string name);
    logic [31:0] exp_res;
    int exp_st, stalls;
    bit seen;
    exp_res = ref_result(op, a, b);
    exp_st  = ref_stalls(op, a, b);
    stalls  = 0;
    seen    = 1'b0;
    ex_muldiv_req = 1'b1;
    ex_muldiv_op  = op;
    ex_rs1        = a;
    ex_rs2        = b;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (muldiv_done) begin
        seen = 1'b1;
        break;
      end
      if (muldiv_stall_req) stalls++;
      @(negedge clk); #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: done=%0b after 100 cycles, required 1", name, muldiv_done);
    end else begin
      checks++;
      if (muldiv_result !== exp_res) begin
        errors++;
        $display("FAIL %s result: got %h, required %h", name, muldiv_result, exp_res);
      end
      checks++;
      if (stalls !== exp_st) begin
        errors++;
        $display("FAIL %s stall cycles: got %0d, required %0d", name, stalls, exp_st);
      end
      checks++;
      if (muldiv_stall_req !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_req in done: got %0b, required 0", name, muldiv_stall_req);
      end
      for (int k = 0; k < hold; k++) begin
        ex_stall = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (muldiv_done !== 1'b1 || muldiv_result !== exp_res) begin
          errors++;
          $display("FAIL %s held cycle %0d: done=%0b result=%h, required done=1 result=%h",
                   name, k, muldiv_done, muldiv_result, exp_res);
        end
      end
      ex_stall = 1'b0;
    end
    @(negedge clk);
    ex_muldiv_req = 1'b0;
    #1;
    checks++;
    if (muldiv_done !== 1'b0) begin
      errors++;
      $display("FAIL %s release: done=%0b, required 0", name, muldiv_done);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    ex_muldiv_req = 1'b0; ex_muldiv_op = 3'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0;
    ex_flush = 1'b0; ex_stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (muldiv_done !== 1'b0 || muldiv_result !== 32'd0 || muldiv_stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset: done=%0b result=%h stall=%0b, required 0/0/0",
               muldiv_done, muldiv_result, muldiv_stall_req);
    end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7x-3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_ones");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_ones");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ones");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_-7/2");
    run_op(3'd5, 32'd5, 32'd0, 0, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, 0, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 0, "divu_max");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = $urandom_range(0, 15);
        default: ;
      endcase
      run_op(op, a, b, int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  task automatic test_flush();
    bit done_seen;
    // Request coincident with flush must not be accepted
    ex_muldiv_req = 1'b1; ex_muldiv_op = 3'd5; ex_rs1 = 32'd5; ex_rs2 = 32'd0; ex_flush = 1'b1;
    #1;
    checks++;
    if (muldiv_stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_coincident stall_req: got %0b, required 0", muldiv_stall_req);
    end
    @(negedge clk);
    ex_muldiv_req = 1'b0; ex_flush = 1'b0;
    #1;
    checks++;
    if (muldiv_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_coincident accepted: done=%0b, required 0", muldiv_done);
    end
    // Flush in the middle of a divide
    @(negedge clk);
    ex_muldiv_req = 1'b1; ex_muldiv_op = 3'd5; ex_rs1 = 32'd100; ex_rs2 = 32'd3;
    repeat (11) @(negedge clk);
    ex_flush = 1'b1;
    #1;
    checks++;
    if (muldiv_stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_mid stall_req: got %0b, required 0", muldiv_stall_req);
    end
    @(negedge clk);
    ex_flush = 1'b0; ex_muldiv_req = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (muldiv_done) done_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_mid discarded: done seen=%0b, required 0", done_seen);
    end
    run_op(3'd5, 32'd100, 32'd3, 0, "divu_after_flush");
  endtask

  task automatic test_stall();
    run_op(3'd7, 32'd100, 32'd7, 4, "remu_held");
  endtask

  task automatic test_reset_mid();
    ex_muldiv_req = 1'b1; ex_muldiv_op = 3'd4; ex_rs1 = 32'd1000; ex_rs2 = 32'd7;
    repeat (12) @(negedge clk);
    rst_b = 1'b0;
    ex_muldiv_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (muldiv_done !== 1'b0 || muldiv_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: done=%0b result=%h, required 0/0", muldiv_done, muldiv_result);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    run_op(3'd4, 32'd1000, 32'd7, 0, "div_after_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_directed();
    test_back_to_back();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
